// File: rtl/goertzel_tone_gen.sv
// Bin-aligned sinusoid burst generator: 2^SIZE_POW2 samples from a recursive oscillator on a valid/ready stream.
// Define GOERTZEL_TONE_GEN_SAT_EN to clamp data_o symmetrically instead of wrapping.
module goertzel_tone_gen #(
   parameter real FREQ       = 16000.0,
   parameter real SAMP_RATE  = 64000.0,
   parameter int  SIZE_POW2  = 6,
   parameter int  DW         = 16,
   parameter int  COEFF_BITS = 24,
   parameter int  GUARD_BITS = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic [DW-1:0] amp_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   output logic          busy_o,
   output logic          done_o
);

   localparam int  N       = 1 << SIZE_POW2;
   localparam int  K       = $rtoi(0.5 + real'(N) * FREQ / SAMP_RATE);
   localparam real PI      = 3.14159265358979323846;
   localparam real OMEGA   = 2.0 * PI * real'(K) / real'(N);
   localparam real SCALE   = real'(longint'(1) << (COEFF_BITS - 2));
   localparam int  IW      = DW + GUARD_BITS + 2;
   // One extra bit so that 2*cos(0) = 2.0 is representable.
   localparam int  CW      = COEFF_BITS + 1;
   localparam int  PW      = IW + CW;
   localparam int  AW      = DW + 1 + CW;
   localparam int  SEED_SH = COEFF_BITS - 2 - GUARD_BITS;

   localparam logic signed [CW-1:0] SINE  = CW'($rtoi($sin(OMEGA) * SCALE));
   localparam logic signed [CW-1:0] COEFF = CW'(2 * $rtoi($cos(OMEGA) * SCALE));

   typedef enum logic [1:0] {S_IDLE, S_SEED, S_RUN, S_DONE} state_t;

   state_t                 state_q, state_d;
   logic [DW-1:0]          amp_q, amp_d;
   logic signed [IW-1:0]   y1_q, y1_d;
   logic signed [IW-1:0]   y2_q, y2_d;
   logic [SIZE_POW2-1:0]   count_q, count_d;
   logic                   valid_q, valid_d;
   logic [DW-1:0]          data_q, data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic signed [PW-1:0]   prod;
   logic signed [IW-1:0]   mult;
   logic signed [AW-1:0]   seed_prod;
   logic signed [IW-1:0]   seed_val;
   logic signed [IW-1:0]   shifted;

`ifdef GOERTZEL_TONE_GEN_SAT_EN
   localparam logic signed [IW-1:0] SAT_HI = IW'((longint'(1) << (DW - 1)) - 1);
   localparam logic signed [IW-1:0] SAT_LO = -SAT_HI;
`endif

   always_comb begin
      state_d   = state_q;
      amp_d     = amp_q;
      y1_d      = y1_q;
      y2_d      = y2_q;
      count_d   = count_q;

      prod      = y1_q * COEFF;
      mult      = IW'(prod >>> (COEFF_BITS - 2));
      seed_prod = $signed({1'b0, amp_q}) * SINE;
      seed_val  = IW'(seed_prod >>> SEED_SH);

      case (state_q)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               state_d = S_SEED;
               amp_d   = amp_i;
            end
         end
         S_SEED: begin
            y1_d    = '0;
            y2_d    = -seed_val;
            count_d = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (ready_i) begin
               y1_d    = mult - y2_q;
               y2_d    = y1_q;
               count_d = count_q + SIZE_POW2'(1);
               if (count_q == '1) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort_i) begin
         state_d = S_IDLE;
         y1_d    = '0;
         y2_d    = '0;
         count_d = '0;
      end

      // Output is registered from the next oscillator value so it lines up with valid_o.
      shifted = y1_d >>> GUARD_BITS;
`ifdef GOERTZEL_TONE_GEN_SAT_EN
      if (shifted > SAT_HI)      data_d = DW'(SAT_HI);
      else if (shifted < SAT_LO) data_d = DW'(SAT_LO);
      else                       data_d = DW'(shifted);
`else
      data_d = DW'(shifted);
`endif

      valid_d = (state_d == S_RUN);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         amp_q   <= '0;
         y1_q    <= '0;
         y2_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         amp_q   <= amp_d;
         y1_q    <= y1_d;
         y2_q    <= y2_d;
         count_q <= count_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: tb/tb_goertzel_tone_gen.sv
// Scoreboard bench for goertzel_tone_gen: two instances (16 kHz and 8 kHz bins) checked against A*sin(2*pi*k*n/N).
module tb_goertzel_tone_gen;

   localparam int N = 64;

   typedef struct {
      int  inst;
      real val;
      real tol;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i [2];
   logic        abort_i [2];
   logic [15:0] amp_i   [2];
   logic        ready_i [2];
   logic        valid_o [2];
   logic [15:0] data_o  [2];
   logic        busy_o  [2];
   logic        done_o  [2];

   int total = 0;
   int bad   = 0;
   int xfer_cnt [2];
   int done_cnt [2];
   logic        stalled   [2];
   logic [15:0] hold_data [2];
   exp_t exp_q [$];

   always #5 clk = ~clk;

   goertzel_tone_gen #(.FREQ(16000.0), .SAMP_RATE(64000.0), .SIZE_POW2(6), .DW(16)) u_dut0 (
      .clk(clk), .rst(rst), .start_i(start_i[0]), .abort_i(abort_i[0]), .amp_i(amp_i[0]),
      .ready_i(ready_i[0]), .valid_o(valid_o[0]), .data_o(data_o[0]), .busy_o(busy_o[0]), .done_o(done_o[0]));

   goertzel_tone_gen #(.FREQ(8000.0), .SAMP_RATE(64000.0), .SIZE_POW2(6), .DW(16)) u_dut1 (
      .clk(clk), .rst(rst), .start_i(start_i[1]), .abort_i(abort_i[1]), .amp_i(amp_i[1]),
      .ready_i(ready_i[1]), .valid_o(valid_o[1]), .data_o(data_o[1]), .busy_o(busy_o[1]), .done_o(done_o[1]));

   function automatic real ideal(input int id, input int a, input int n);
      real freq;
      int  k;
      freq = (id == 0) ? 16000.0 : 8000.0;
      k = $rtoi(0.5 + real'(N) * freq / 64000.0);
      return real'(a) * $sin(2.0 * 3.14159265358979323846 * real'(k) * real'(n) / real'(N));
   endfunction

   function automatic int fix16(input int x);
`ifdef GOERTZEL_TONE_GEN_SAT_EN
      if (x > 32767) return 32767;
      if (x < -32767) return -32767;
      return x;
`else
      return (((x + 32768) % 65536) + 65536) % 65536 - 32768;
`endif
   endfunction

   function automatic exp_t make_exp(input int id, input int a, input int n);
      exp_t e;
      real  v;
      int   r;
      v = ideal(id, a, n);
      e.inst = id;
      if (id == 0) begin
         r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
         e.val = real'(fix16(r));
         e.tol = 0.0;
      end else begin
         e.val = v;
         e.tol = 2.0;
      end
      return e;
   endfunction

   // Monitor: pops one expectation per transfer and checks hold-while-stalled.
   always @(negedge clk) begin
      exp_t e;
      real  d;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            stalled[i] = 1'b0;
         end else begin
            if (done_o[i]) done_cnt[i]++;
            if (valid_o[i] && stalled[i]) begin
               total++;
               if (data_o[i] != hold_data[i]) begin
                  bad++;
                  $display("FAIL stall_hold inst%0d: got %0d expected %0d", i,
                           $signed(data_o[i]), $signed(hold_data[i]));
               end
            end
            stalled[i]   = valid_o[i] && !ready_i[i];
            hold_data[i] = data_o[i];
            if (valid_o[i] && ready_i[i]) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_sample inst%0d: got %0d expected none", i, $signed(data_o[i]));
               end else begin
                  e = exp_q.pop_front();
                  d = real'(int'($signed(data_o[i]))) - e.val;
                  if (d < 0.0) d = -d;
                  if (e.inst != i || d > e.tol) begin
                     bad++;
                     $display("FAIL sample inst%0d xfer%0d: got %0d expected %f (inst%0d tol %f)", i,
                              xfer_cnt[i], $signed(data_o[i]), e.val, e.inst, e.tol);
                  end
               end
               xfer_cnt[i]++;
            end
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_burst(input int id, input int a, input int duty, input bit mid_start);
      int base_x, base_d, cyc, lat;
      bit got_done;
      for (int n = 0; n < N; n++) exp_q.push_back(make_exp(id, a, n));
      base_x = xfer_cnt[id];
      base_d = done_cnt[id];
      amp_i[id]   = 16'(a);
      start_i[id] = 1'b1;
      ready_i[id] = (int'($urandom_range(99, 0)) < duty);
      lat = -1;
      cyc = 0;
      got_done = 1'b0;
      while (!got_done && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         start_i[id] = mid_start && (cyc == 20);
         amp_i[id]   = 16'($urandom);
         ready_i[id] = (int'($urandom_range(99, 0)) < duty);
         if (cyc == 1) begin
            check("seed_valid", int'(valid_o[id]), 0);
            check("seed_busy", int'(busy_o[id]), 1);
         end
         if (lat < 0 && valid_o[id]) lat = cyc;
         if (done_o[id]) got_done = 1'b1;
      end
      check("start_latency", lat, 2);
      check("burst_done", int'(got_done), 1);
      check("done_busy", int'(busy_o[id]), 1);
      check("done_valid", int'(valid_o[id]), 0);
      ready_i[id] = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", int'(busy_o[id]), 0);
      check("idle_done", int'(done_o[id]), 0);
      check("transfers", xfer_cnt[id] - base_x, N);
      check("done_pulses", done_cnt[id] - base_d, 1);
      check("queue_empty", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int base_x, base_d, cyc, a;
      for (int i = 0; i < 2; i++) begin
         start_i[i] = 1'b0; abort_i[i] = 1'b0; amp_i[i] = '0; ready_i[i] = 1'b0;
         xfer_cnt[i] = 0; done_cnt[i] = 0; stalled[i] = 1'b0; hold_data[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         check("rst_valid", int'(valid_o[i]), 0);
         check("rst_data", int'(data_o[i]), 0);
         check("rst_busy", int'(busy_o[i]), 0);
         check("rst_done", int'(done_o[i]), 0);
      end
      rst = 1'b0;

      run_burst(0, 10000, 100, 1'b0);
      run_burst(0, 10000, 30, 1'b0);
      run_burst(1, 10000, 100, 1'b0);
      for (int r = 0; r < 3; r++)
         run_burst(1, int'($urandom_range(30000, 1)), int'($urandom_range(100, 20)), 1'b0);
      run_burst(0, 40000, 100, 1'b0);
      run_burst(0, 0, 60, 1'b0);
      for (int r = 0; r < 2; r++)
         run_burst(0, int'($urandom_range(65535, 0)), int'($urandom_range(100, 30)), 1'b0);

      // abort together with start in IDLE must not leave IDLE
      @(posedge clk); #1;
      start_i[0] = 1'b1; abort_i[0] = 1'b1; amp_i[0] = 16'd5000;
      @(posedge clk); #1;
      start_i[0] = 1'b0; abort_i[0] = 1'b0;
      check("abort_start_busy", int'(busy_o[0]), 0);
      @(posedge clk); #1;
      check("abort_start_valid", int'(valid_o[0]), 0);
      check("abort_start_busy2", int'(busy_o[0]), 0);

      // abort after 10 transfers
      a = int'($urandom_range(30000, 1000));
      for (int n = 0; n < 10; n++) exp_q.push_back(make_exp(0, a, n));
      base_x = xfer_cnt[0];
      amp_i[0] = 16'(a); ready_i[0] = 1'b1; start_i[0] = 1'b1;
      cyc = 0;
      while (xfer_cnt[0] - base_x < 10 && cyc < 500) begin
         @(posedge clk); #1;
         start_i[0] = 1'b0;
         cyc++;
      end
      check("abort_reach10", xfer_cnt[0] - base_x, 10);
      base_d = done_cnt[0];
      abort_i[0] = 1'b1; ready_i[0] = 1'b0;
      @(posedge clk); #1;
      abort_i[0] = 1'b0;
      check("abort_valid", int'(valid_o[0]), 0);
      check("abort_busy", int'(busy_o[0]), 0);
      check("abort_done", int'(done_o[0]), 0);
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt[0] - base_d, 0);
      check("abort_xfers", xfer_cnt[0] - base_x, 10);
      exp_q.delete();
      run_burst(0, 12345, 100, 1'b1);

      // reset mid-burst
      a = int'($urandom_range(30000, 1000));
      for (int n = 0; n < N; n++) exp_q.push_back(make_exp(1, a, n));
      amp_i[1] = 16'(a); ready_i[1] = 1'b1; start_i[1] = 1'b1;
      @(posedge clk); #1;
      start_i[1] = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_valid", int'(valid_o[1]), 0);
      check("midrst_data", int'(data_o[1]), 0);
      check("midrst_busy", int'(busy_o[1]), 0);
      check("midrst_done", int'(done_o[1]), 0);
      exp_q.delete();
      ready_i[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_burst(1, int'($urandom_range(30000, 1)), 70, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
